// File: rtl/wb_stage_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_defs : shared load-kind encoding and reset PC for the core.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_defs;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LB      = 3'd1,
    LBU     = 3'd2,
    LH      = 3'd3,
    LHU     = 3'd4,
    LW      = 3'd5,
    LWL     = 3'd6,
    LWR     = 3'd7
  } load_op_e;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

endpackage

`default_nettype wire

// File: rtl/wb_stage_if.sv
// +--------------------------------------------------------------------+
// | wb_stage_if : MEM->WB handshake, data-SRAM response, commit bus.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface wb_stage_if;
  import cpu_defs::*;

  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic        ms_wen;
  logic [4:0]  ms_waddr;
  logic [31:0] ms_result;
  load_op_e    ms_load_op;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_rt_old;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        ws_flush;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] wb_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic        fwd_data_ok;
  logic [31:0] retire_cnt;

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_wen, ms_waddr, ms_result, ms_load_op,
           ms_addr_lo, ms_rt_old, data_rdata, data_ok, ws_flush,
    output ws_allowin, rf_wen, rf_waddr, rf_wdata, wb_pc,
           fwd_valid, fwd_addr, fwd_data_ok, retire_cnt
  );

  modport master (
    output ms_to_ws_valid, ms_pc, ms_wen, ms_waddr, ms_result, ms_load_op,
           ms_addr_lo, ms_rt_old, data_rdata, data_ok, ws_flush,
    input  ws_allowin, rf_wen, rf_waddr, rf_wdata, wb_pc,
           fwd_valid, fwd_addr, fwd_data_ok, retire_cnt
  );

endinterface

`default_nettype wire

// File: rtl/wb_stage_load_align.sv
// +--------------------------------------------------------------------+
// | load_align : little-endian load extraction and LWL/LWR merge.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module load_align
  import cpu_defs::*;
(
  input  load_op_e    i_load_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_rt_old,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    // Halfword alignment faults are raised upstream, so only bit 1 matters.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_value = i_rdata;
    case (i_load_op)
      LB:  o_value = {{24{w_byte[7]}}, w_byte};
      LBU: o_value = {24'h0, w_byte};
      LH:  o_value = {{16{w_half[15]}}, w_half};
      LHU: o_value = {16'h0, w_half};
      LWL: begin
        case (i_addr_lo)
          2'd0:    o_value = {i_rdata[7:0],  i_rt_old[23:0]};
          2'd1:    o_value = {i_rdata[15:0], i_rt_old[15:0]};
          2'd2:    o_value = {i_rdata[23:0], i_rt_old[7:0]};
          default: o_value = i_rdata;
        endcase
      end
      LWR: begin
        case (i_addr_lo)
          2'd0:    o_value = i_rdata;
          2'd1:    o_value = {i_rt_old[31:24], i_rdata[31:8]};
          2'd2:    o_value = {i_rt_old[31:16], i_rdata[31:16]};
          default: o_value = {i_rt_old[31:8],  i_rdata[31:24]};
        endcase
      end
      default: o_value = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
// +--------------------------------------------------------------------+
// | wb_stage : writeback stage; latches MEM result, waits for load     |
// | data, aligns it and drives the regfile write port. Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module wb_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   bus
);

  logic               r_ws_valid;
  logic [31:0]        r_pc;
  logic               r_wen;
  logic [4:0]         r_waddr;
  logic [31:0]        r_result;
  cpu_defs::load_op_e r_load_op;
  logic [1:0]         r_addr_lo;
  logic [31:0]        r_rt_old;
  logic [31:0]        r_retire_cnt;

  logic        w_is_load;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_retire;
  logic        w_capture;
  logic        w_has_dest;
  logic [31:0] w_load_value;

  assign w_is_load  = (r_load_op != cpu_defs::LD_NONE);
  assign w_ready_go = ~w_is_load | bus.data_ok;
  assign w_allowin  = ~r_ws_valid | w_ready_go;
  assign w_retire   = r_ws_valid & w_ready_go & ~bus.ws_flush;
  assign w_capture  = w_allowin & ~bus.ws_flush & bus.ms_to_ws_valid;
  assign w_has_dest = r_wen & (r_waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid   <= 1'b0;
      r_pc         <= RESET_PC;
      r_wen        <= 1'b0;
      r_waddr      <= 5'd0;
      r_result     <= 32'd0;
      r_load_op    <= cpu_defs::LD_NONE;
      r_addr_lo    <= 2'd0;
      r_rt_old     <= 32'd0;
      r_retire_cnt <= 32'd0;
    end else begin
      if (bus.ws_flush) begin
        r_ws_valid <= 1'b0;
      end else if (w_allowin) begin
        r_ws_valid <= bus.ms_to_ws_valid;
      end
      if (w_capture) begin
        r_pc      <= bus.ms_pc;
        r_wen     <= bus.ms_wen;
        r_waddr   <= bus.ms_waddr;
        r_result  <= bus.ms_result;
        r_load_op <= bus.ms_load_op;
        r_addr_lo <= bus.ms_addr_lo;
        r_rt_old  <= bus.ms_rt_old;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  load_align u_load_align (
    .i_load_op (r_load_op),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (bus.data_rdata),
    .i_rt_old  (r_rt_old),
    .o_value   (w_load_value)
  );

  assign bus.ws_allowin  = w_allowin;
  assign bus.rf_wen      = w_retire & w_has_dest;
  assign bus.rf_waddr    = r_waddr;
  assign bus.rf_wdata    = w_is_load ? w_load_value : r_result;
  assign bus.wb_pc       = r_pc;
  assign bus.fwd_valid   = r_ws_valid & w_has_dest;
  assign bus.fwd_addr    = r_waddr;
  assign bus.fwd_data_ok = w_ready_go;
  assign bus.retire_cnt  = r_retire_cnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// +--------------------------------------------------------------------+
// | tb_wb_stage : directed-vector self-checking bench for wb_stage.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_wb_stage;
  import cpu_defs::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wb_stage_if bus ();

  wb_stage #(.RESET_PC(32'hBFC0_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for exactly one edge; returns 1 time unit after it.
  task automatic send(input logic [31:0] pc, input logic wen, input logic [4:0] waddr,
                      input logic [31:0] result, input load_op_e op,
                      input logic [1:0] lo, input logic [31:0] rt);
    bus.ms_to_ws_valid = 1'b1;
    bus.ms_pc      = pc;
    bus.ms_wen     = wen;
    bus.ms_waddr   = waddr;
    bus.ms_result  = result;
    bus.ms_load_op = op;
    bus.ms_addr_lo = lo;
    bus.ms_rt_old  = rt;
    tick();
    bus.ms_to_ws_valid = 1'b0;
  endtask

  task automatic do_load(input string tag, input load_op_e op, input logic [1:0] lo,
                         input logic [31:0] rt, input logic [31:0] data,
                         input logic [31:0] exp);
    send(32'h300, 1'b1, 5'd8, 32'hDEAD_BEEF, op, lo, rt);
    bus.data_rdata = data;
    bus.data_ok    = 1'b1;
    #1;
    chk({tag, "_wen"}, {31'd0, bus.rf_wen}, 32'd1);
    chk(tag, bus.rf_wdata, exp);
    tick();
    bus.data_ok = 1'b0;
  endtask

  logic [31:0] base_cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.ms_to_ws_valid = 1'b0;
    bus.ms_pc      = 32'd0;
    bus.ms_wen     = 1'b0;
    bus.ms_waddr   = 5'd0;
    bus.ms_result  = 32'd0;
    bus.ms_load_op = LD_NONE;
    bus.ms_addr_lo = 2'd0;
    bus.ms_rt_old  = 32'd0;
    bus.data_rdata = 32'd0;
    bus.data_ok    = 1'b0;
    bus.ws_flush   = 1'b0;

    repeat (3) tick();
    chk("rst_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("rst_allowin", {31'd0, bus.ws_allowin}, 32'd1);
    chk("rst_pc", bus.wb_pc, 32'hBFC0_0000);
    chk("rst_cnt", bus.retire_cnt, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    chk("post_rst_pc", bus.wb_pc, 32'hBFC0_0000);

    // ALU result commits the cycle after capture
    send(32'h100, 1'b1, 5'd5, 32'h1234, LD_NONE, 2'd0, 32'd0);
    chk("addu_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("addu_waddr", {27'd0, bus.rf_waddr}, 32'd5);
    chk("addu_wdata", bus.rf_wdata, 32'h1234);
    chk("addu_pc", bus.wb_pc, 32'h100);
    chk("addu_fwd", {30'd0, bus.fwd_valid, bus.fwd_data_ok}, 32'd3);
    tick();
    chk("addu_cnt", bus.retire_cnt, 32'd1);

    send(32'h104, 1'b1, 5'd0, 32'h55, LD_NONE, 2'd0, 32'd0);
    chk("r0_wen", {31'd0, bus.rf_wen}, 32'd0);
    chk("r0_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    tick();
    chk("r0_cnt", bus.retire_cnt, 32'd2);

    // LB stalled three cycles on data_ok
    send(32'h108, 1'b1, 5'd7, 32'd0, LB, 2'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall_allowin", {31'd0, bus.ws_allowin}, 32'd0);
      chk("lb_stall_wen", {31'd0, bus.rf_wen}, 32'd0);
      chk("lb_stall_fwd", {30'd0, bus.fwd_valid, bus.fwd_data_ok}, 32'd2);
      tick();
    end
    bus.data_rdata = 32'h1180_2233;
    bus.data_ok    = 1'b1;
    #1;
    chk("lb_wen", {31'd0, bus.rf_wen}, 32'd1);
    chk("lb_wdata", bus.rf_wdata, 32'hFFFF_FF80);
    chk("lb_allowin", {31'd0, bus.ws_allowin}, 32'd1);
    tick();
    bus.data_ok = 1'b0;
    chk("lb_cnt", bus.retire_cnt, 32'd3);

    do_load("lwl1", LWL, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
    do_load("lwr2", LWR, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
    do_load("lhu2", LHU, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'h0000_1122);
    do_load("lh0",  LH,  2'd0, 32'd0,         32'h1234_8001, 32'hFFFF_8001);
    do_load("lbu3", LBU, 2'd3, 32'd0,         32'h9A00_0000, 32'h0000_009A);
    do_load("lwl0", LWL, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD);
    do_load("lwr3", LWR, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11);
    do_load("lw",   LW,  2'd0, 32'd0,         32'hCAFE_F00D, 32'hCAFE_F00D);
    chk("load_cnt", bus.retire_cnt, 32'd11);

    // Flush coinciding with data_ok cancels the load
    send(32'h200, 1'b1, 5'd9, 32'd0, LW, 2'd0, 32'd0);
    tick();
    bus.data_ok  = 1'b1;
    bus.ws_flush = 1'b1;
    #1;
    chk("flush_wen", {31'd0, bus.rf_wen}, 32'd0);
    tick();
    bus.data_ok  = 1'b0;
    bus.ws_flush = 1'b0;
    chk("flush_cnt", bus.retire_cnt, 32'd11);
    chk("flush_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    chk("flush_allowin", {31'd0, bus.ws_allowin}, 32'd1);

    bus.data_ok = 1'b1;
    #1;
    chk("stray_wen", {31'd0, bus.rf_wen}, 32'd0);
    tick();
    bus.data_ok = 1'b0;
    chk("stray_cnt", bus.retire_cnt, 32'd11);

    // Four back-to-back ALU ops, one write per cycle
    base_cnt = bus.retire_cnt;
    bus.ms_load_op = LD_NONE;
    bus.ms_wen     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ms_to_ws_valid = 1'b1;
      bus.ms_pc     = 32'h400 + 32'(i * 4);
      bus.ms_waddr  = 5'(10 + i);
      bus.ms_result = 32'hA0 + 32'(i);
      tick();
      chk("b2b_wen", {31'd0, bus.rf_wen}, 32'd1);
      chk("b2b_waddr", {27'd0, bus.rf_waddr}, 32'(10 + i));
      chk("b2b_wdata", bus.rf_wdata, 32'hA0 + 32'(i));
      chk("b2b_pc", bus.wb_pc, 32'h400 + 32'(i * 4));
    end
    bus.ms_to_ws_valid = 1'b0;
    tick();
    chk("b2b_cnt", bus.retire_cnt, base_cnt + 32'd4);

    // Reset in the middle of a load stall
    send(32'h500, 1'b1, 5'd3, 32'd0, LW, 2'd0, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_stall_cnt", bus.retire_cnt, 32'd0);
    chk("rst_stall_fwd", {31'd0, bus.fwd_valid}, 32'd0);
    chk("rst_stall_allowin", {31'd0, bus.ws_allowin}, 32'd1);
    bus.data_ok = 1'b1;
    #1;
    chk("rst_stray_wen", {31'd0, bus.rf_wen}, 32'd0);
    tick();
    bus.data_ok = 1'b0;
    chk("rst_stray_cnt", bus.retire_cnt, 32'd0);

    // Retire counter wrap
    force dut.r_retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire_cnt;
    #1;
    chk("wrap_pre", bus.retire_cnt, 32'hFFFF_FFFF);
    send(32'h600, 1'b0, 5'd0, 32'd0, LD_NONE, 2'd0, 32'd0);
    chk("wrap_hold", bus.retire_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap_zero", bus.retire_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Final (writeback) pipeline stage of the single-issue MIPS core. Latches the MEM-stage result through a valid/allowin handshake and waits for the data-SRAM response on loads. Performs byte/half/LWL/LWR load extraction and merging, then drives the register file's single write port and the commit PC (`count`). Also exposes a forwarding view of the in-flight destination and a retired-instruction counter.

Parameters:
- RESET_PC, 32'hBFC0_0000, value of wb_pc after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- ms_to_ws_valid  in  1  MEM stage presents an instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  instruction PC
- ms_wen  in  1  instruction writes GPR
- ms_waddr  in  5  destination GPR
- ms_result  in  32  ALU/link result (non-load)
- ms_load_op  in  3  load kind (package enum)
- ms_addr_lo  in  2  effective address [1:0]
- ms_rt_old  in  32  old rt value for LWL/LWR merge
- data_rdata  in  32  data-SRAM read word
- data_ok  in  1  data_rdata valid this cycle (one-cycle pulse)
- ws_flush  in  1  exception/ERET cancel
- rf_wen  out  1  regfile write enable
- rf_waddr  out  5  regfile write address
- rf_wdata  out  32  regfile write data
- wb_pc  out  32  committing PC (drives regfile `count`)
- fwd_valid  out  1  WB holds a pending GPR write (for hazard unit)
- fwd_addr  out  5  its destination
- fwd_data_ok  out  1  fwd value is final (non-load, or load with data_ok)
- retire_cnt  out  32  retired-instruction count

Behaviour:
- State regs: ws_valid, pc, wen, waddr, result, load_op, addr_lo, rt_old.
- Reset values: ws_valid=0, pc=RESET_PC, all other state and retire_cnt=0. Hence rf_wen=0, fwd_valid=0, ws_allowin=1 during and after reset.
- ws_ready_go = ~(load_op != LD_NONE) | data_ok.
- ws_allowin = ~ws_valid | ws_ready_go.
- Capture: at a posedge with ws_allowin & ~ws_flush, ws_valid <= ms_to_ws_valid. The payload is latched only when ms_to_ws_valid=1.
- Flush: ws_flush=1 clears ws_valid at the next edge. It suppresses rf_wen and retire in the same cycle, and blocks capture.
- Commit is combinational: rf_wen = ws_valid & ws_ready_go & wen & (waddr != 0) & ~ws_flush.
  - rf_waddr = waddr; wb_pc = pc.
  - rf_wdata = load_op==LD_NONE ? result : extracted load value.
- Latency: an instruction accepted at edge N writes the regfile at edge N+1 if it is not a load. A load waits until the data_ok cycle.
- While stalled on data_ok, ws_allowin=0 and the payload holds.
- data_ok while ~ws_valid or load_op==LD_NONE is ignored.
- Load extraction (little-endian), with b = data_rdata byte at addr_lo and h = halfword at addr_lo[1]:
  - LB: sign-extend b. LBU: zero-extend b.
  - LH: sign-extend h. LHU: zero-extend h. addr_lo[0] is ignored (alignment is trapped upstream).
  - LW: data_rdata.
- LWL by addr_lo:
  - 0: {w[7:0], rt[23:0]}
  - 1: {w[15:0], rt[15:0]}
  - 2: {w[23:0], rt[7:0]}
  - 3: w
- LWR by addr_lo:
  - 0: w
  - 1: {rt[31:24], w[31:8]}
  - 2: {rt[31:16], w[31:16]}
  - 3: {rt[31:8], w[31:24]}
- fwd_valid = ws_valid & wen & (waddr != 0); fwd_addr = waddr; fwd_data_ok = ws_ready_go.
- retire_cnt increments by 1, wrapping at 2^32, on every cycle with ws_valid & ws_ready_go & ~ws_flush, including wen=0 instructions.
- Back-to-back: an instruction retiring at edge N and a new one captured at edge N are allowed; there is no bubble.
- Reset asserted mid-stall discards the pending load. A later stray data_ok has no effect.

Decomposition:
- Shared package `cpu_defs`:
  - load_op enum: LD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7
  - RESET_PC constant
- One natural sub-module, `load_align`: purely combinational (load_op, addr_lo, data_rdata, rt_old) -> 32-bit value, instantiated once.

Test Plan:
- Reset 3 cycles, then release -> rf_wen=0, ws_allowin=1, wb_pc=32'hBFC0_0000, retire_cnt=0.
- ADDU: pc=0x100, waddr=5, result=0x1234 accepted -> next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, wb_pc=0x100, retire_cnt=1. Same test with waddr=0 -> rf_wen=0, retire_cnt still increments.
- LB: addr_lo=2, data_ok withheld 3 cycles, then data_rdata=0x11_80_22_33 -> ws_allowin=0 and rf_wen=0 while stalled, fwd_data_ok=0. On the data_ok cycle rf_wdata=0xFFFFFF80.
- LWL/LWR: rt_old=0xAABBCCDD, data=0x11223344:
  - LWL addr_lo=1 -> 0x3344CCDD
  - LWR addr_lo=2 -> 0xAABB1122
  - LHU addr_lo=2 -> 0x00001122
- ws_flush asserted during a load stall, with data_ok in the same cycle -> no rf_wen, retire_cnt unchanged, ws_valid=0 next cycle.
- Stream of 4 back-to-back non-loads -> one write per cycle in order, retire_cnt=4. Retire_cnt preloaded to 0xFFFFFFFF via long run -> wraps to 0.
